// File: rtl/mem_bridge_if.sv
// mem_bridge_pkg / mem_bridge_if
// Common bus types for the uncached memory bridge, and the interface that
// bundles the bridge's CPU-side and cache-bus-side struct ports.
//   ireq/iresp : instruction bus request/response
//   dreq/dresp : data bus request/response
//   creq/cresp : cache-bus (cbus) request/response
// Modports:
//   slave  - the bridge (consumes ireq/dreq/cresp, produces iresp/dresp/creq)
//   master - the environment driving CPU requests and memory responses
package mem_bridge_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [31:0] u32_t;
  typedef logic [7:0]  strobe_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u32_t data;
  } ibus_resp_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef struct packed {
    logic       valid;
    logic       is_write;
    msize_t     size;
    addr_t      addr;
    strobe_t    strobe;
    word_t      data;
    mlen_t      len;
    axi_burst_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;

endpackage

interface mem_bridge_if;
  import mem_bridge_pkg::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  modport slave  (input ireq, dreq, cresp, output iresp, dresp, creq);
  modport master (output ireq, dreq, cresp, input iresp, dresp, creq);

endinterface

// File: rtl/mem_bridge.sv
// mem_bridge
// Uncached bridge: arbitrates one ibus and one dbus request onto a single-beat
// cbus transaction and returns the result on the originating bus.
// Ports:
//   clk     - single clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - mem_bridge_if.slave carrying ireq/iresp, dreq/dresp, creq/cresp
// Build option:
//   MEM_BRIDGE_RR_ARB_EN - defined: round-robin between ibus and dbus when both
//                          are valid; undefined: dbus has fixed priority.
module mem_bridge
  import mem_bridge_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  mem_bridge_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t    state_q, state_d;
  logic      grant_q, grant_d;   // 0 = ibus, 1 = dbus
  dbus_req_t req_q,   req_d;
  word_t     rdata_q, rdata_d;

  logic      pick_dbus;
  dbus_req_t ireq_mapped;

  // Instruction fetches travel as 4-byte reads in the dbus request format.
  always_comb begin
    ireq_mapped        = '0;
    ireq_mapped.valid  = bus.ireq.valid;
    ireq_mapped.addr   = bus.ireq.addr;
    ireq_mapped.size   = MSIZE4;
    ireq_mapped.strobe = '0;
    ireq_mapped.data   = '0;
  end

  always_comb begin
    pick_dbus = bus.dreq.valid;
`ifdef MEM_BRIDGE_RR_ARB_EN
    // On contention the bus not served last time wins.
    if (bus.ireq.valid && bus.dreq.valid) begin
      pick_dbus = ~grant_q;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.ireq.valid || bus.dreq.valid) begin
          grant_d = pick_dbus;
          req_d   = pick_dbus ? bus.dreq : ireq_mapped;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // ready without last is not a completion and is ignored.
        if (bus.cresp.ready && bus.cresp.last) begin
          rdata_d = bus.cresp.data;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= 1'b0;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  // All outputs decode registered state only; reset clears them immediately.
  always_comb begin
    bus.creq  = '0;
    bus.iresp = '0;
    bus.dresp = '0;
    if (state_q == S_REQ) begin
      // req_q is only ever latched from a valid request, so this is 1 here.
      bus.creq.valid    = req_q.valid;
      bus.creq.is_write = |req_q.strobe;
      bus.creq.size     = req_q.size;
      bus.creq.addr     = req_q.addr;
      bus.creq.strobe   = req_q.strobe;
      bus.creq.data     = req_q.data;
      bus.creq.len      = MLEN1;
      bus.creq.burst    = AXI_BURST_FIXED;
    end
    if (state_q == S_DONE) begin
      if (grant_q) begin
        bus.dresp.addr_ok = 1'b1;
        bus.dresp.data_ok = 1'b1;
        bus.dresp.data    = rdata_q;
      end else begin
        bus.iresp.addr_ok = 1'b1;
        bus.iresp.data_ok = 1'b1;
        bus.iresp.data    = req_q.addr[2] ? rdata_q[63:32] : rdata_q[31:0];
      end
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge
// Directed and randomized checks of mem_bridge against a transaction-level
// model: arbitration choice, expected cbus request, stall behaviour, response
// routing and data lane selection. Build with MEM_BRIDGE_RR_ARB_EN to check
// the round-robin arbiter.
module tb_mem_bridge;
  import mem_bridge_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  mem_bridge_if bus ();

  mem_bridge dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // Model state: outstanding requests and last served bus (1 = dbus).
  bit        i_pend, d_pend;
  bit        last_dbus;
  ibus_req_t cur_i;
  dbus_req_t cur_d;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_pick_dbus(input bit iv, input bit dv, input bit last_d);
`ifdef MEM_BRIDGE_RR_ARB_EN
    if (iv && dv) return !last_d;
`endif
    return dv;
  endfunction

  function automatic cbus_req_t model_creq(input bit to_d, input ibus_req_t i, input dbus_req_t d);
    cbus_req_t c;
    c       = '0;
    c.valid = 1'b1;
    c.len   = MLEN1;
    c.burst = AXI_BURST_FIXED;
    if (to_d) begin
      c.addr     = d.addr;
      c.size     = d.size;
      c.strobe   = d.strobe;
      c.data     = d.data;
      c.is_write = (d.strobe != 8'h00);
    end else begin
      c.addr = i.addr;
      c.size = MSIZE4;
    end
    return c;
  endfunction

  task automatic new_i(input addr_t a);
    cur_i       = '0;
    cur_i.valid = 1'b1;
    cur_i.addr  = a;
    bus.ireq    = cur_i;
    i_pend      = 1'b1;
  endtask

  task automatic new_d(input addr_t a, input msize_t sz, input strobe_t st, input word_t dt);
    cur_d        = '0;
    cur_d.valid  = 1'b1;
    cur_d.addr   = a;
    cur_d.size   = sz;
    cur_d.strobe = st;
    cur_d.data   = dt;
    bus.dreq     = cur_d;
    d_pend       = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    bus.ireq  = '0;
    bus.dreq  = '0;
    bus.cresp = '0;
    i_pend    = 1'b0;
    d_pend    = 1'b0;
    last_dbus = 1'b0;
    #1;
    check("reset_creq",  256'(bus.creq),  256'(0));
    check("reset_iresp", 256'(bus.iresp), 256'(0));
    check("reset_dresp", 256'(bus.dresp), 256'(0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Called at a negedge with requests already on the bus and the DUT idle.
  // Returns at the negedge of the IDLE cycle after the response.
  task automatic one_txn(input int stall, input int glitch_at, input bit drop, input word_t rdata);
    bit          to_d;
    cbus_req_t   exp_c;
    ibus_resp_t  exp_i;
    dbus_resp_t  exp_d;
    int unsigned waited;

    to_d  = model_pick_dbus(i_pend, d_pend, last_dbus);
    exp_c = model_creq(to_d, cur_i, cur_d);

    waited = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      waited++;
    end while (!bus.creq.valid && waited < 8);
    check("creq_latency", 256'(waited), 256'(1));
    check("creq_first", 256'(bus.creq), 256'(exp_c));

    if (drop) begin
      if (to_d) bus.dreq.valid = 1'b0;
      else      bus.ireq.valid = 1'b0;
    end

    for (int s = 0; s < stall; s++) begin
      bus.cresp = '0;
      if (s == glitch_at) begin
        bus.cresp.ready = 1'b1;
        bus.cresp.last  = 1'b0;
        bus.cresp.data  = ~rdata;
      end
      @(posedge clk);
      @(negedge clk);
      check("creq_stable", 256'(bus.creq), 256'(exp_c));
      check("resp_quiet_in_req", 256'({bus.iresp, bus.dresp}), 256'(0));
    end

    bus.cresp       = '0;
    bus.cresp.ready = 1'b1;
    bus.cresp.last  = 1'b1;
    bus.cresp.data  = rdata;
    @(posedge clk);
    @(negedge clk);
    bus.cresp = '0;

    exp_i = '0;
    exp_d = '0;
    if (to_d) begin
      exp_d.addr_ok = 1'b1;
      exp_d.data_ok = 1'b1;
      exp_d.data    = rdata;
    end else begin
      exp_i.addr_ok = 1'b1;
      exp_i.data_ok = 1'b1;
      exp_i.data    = 32'(rdata >> (cur_i.addr[2] ? 32 : 0));
    end
    check("creq_off_in_done", 256'(bus.creq), 256'(0));
    check("iresp_done", 256'(bus.iresp), 256'(exp_i));
    check("dresp_done", 256'(bus.dresp), 256'(exp_d));

    if (to_d) begin
      bus.dreq.valid = 1'b0;
      d_pend         = 1'b0;
    end else begin
      bus.ireq.valid = 1'b0;
      i_pend         = 1'b0;
    end
    last_dbus = to_d;

    @(posedge clk);
    @(negedge clk);
    check("iresp_one_cycle", 256'(bus.iresp), 256'(0));
    check("dresp_one_cycle", 256'(bus.dresp), 256'(0));
    check("creq_idle", 256'(bus.creq), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ireq  = '0;
    bus.dreq  = '0;
    bus.cresp = '0;
    cur_i     = '0;
    cur_d     = '0;
    do_reset();

    // Single ibus read from the upper word lane.
    @(negedge clk);
    new_i(64'h0000_0000_8000_0004);
    one_txn(2, -1, 1'b0, 64'h1122_3344_5566_7788);

    // dbus byte write.
    new_d(64'h0000_0000_8000_1003, MSIZE1, 8'h08, 64'h0000_0000_AB00_0000);
    one_txn(1, -1, 1'b0, 64'hDEAD_BEEF_0BAD_F00D);

    // Simultaneous requests from reset; the winner re-requests after service.
    do_reset();
    @(negedge clk);
    new_i(64'h0000_0000_8000_2000);
    new_d(64'h0000_0000_8000_3008, MSIZE8, 8'h00, 64'h0);
    check("simul_first_is_dbus", 256'(model_pick_dbus(i_pend, d_pend, last_dbus)), 256'(1));
    one_txn(0, -1, 1'b0, 64'hA5A5_0000_5A5A_1111);
    new_d(64'h0000_0000_8000_3010, MSIZE8, 8'h00, 64'h0);
    one_txn(0, -1, 1'b0, 64'h0123_4567_89AB_CDEF);
    one_txn(0, -1, 1'b0, 64'hFEDC_BA98_7654_3210);

    // Long stall with a ready-without-last glitch.
    new_d(64'h0000_0000_8000_4000, MSIZE4, 8'h00, 64'h0);
    one_txn(10, 4, 1'b0, 64'h0000_0000_CAFE_F00D);

    // Reset while a request is outstanding on cbus.
    new_i(64'h0000_0000_8000_5000);
    @(posedge clk);
    @(negedge clk);
    check("pre_reset_creq_valid", 256'(bus.creq.valid), 256'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("midreq_reset_creq",  256'(bus.creq),  256'(0));
    check("midreq_reset_iresp", 256'(bus.iresp), 256'(0));
    check("midreq_reset_dresp", 256'(bus.dresp), 256'(0));
    bus.ireq  = '0;
    i_pend    = 1'b0;
    d_pend    = 1'b0;
    last_dbus = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    new_i(64'h0000_0000_8000_6000);
    one_txn(1, -1, 1'b0, 64'h7777_8888_9999_AAAA);

    // dbus drops valid during REQ.
    new_d(64'h0000_0000_8000_7000, MSIZE2, 8'h03, 64'h0000_0000_0000_BEEF);
    one_txn(3, -1, 1'b1, 64'h1357_9BDF_2468_ACE0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if (!i_pend && $urandom_range(0, 1) == 1)
        new_i({$urandom, $urandom} & ~64'h3);
      if (!d_pend && $urandom_range(0, 1) == 1)
        new_d({$urandom, $urandom}, msize_t'($urandom_range(0, 3)),
              ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00,
              {$urandom, $urandom});
      if (!i_pend && !d_pend)
        new_d({$urandom, $urandom}, MSIZE8, 8'h00, 64'h0);
      one_txn(int'($urandom_range(0, 4)),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1,
              $urandom_range(0, 5) == 0,
              {$urandom, $urandom});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
# mem_bridge

Uncached memory bridge between the CPU-side instruction bus and data bus and the single cache-bus (cbus) port to the memory system. It arbitrates between one ibus request and one dbus request. Each granted request becomes a single-beat cbus transaction, and the bridge returns the result on the originating bus. It sits where a cache would sit, serving uncached regions and bring-up configurations without caches.

## Interface
Parameters:
- none; all widths come from the common package (`addr_t`/`word_t` 64-bit, `ibus_*`, `dbus_*`, `cbus_*` structs).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `ireq`  in  `ibus_req_t`  instruction request; `addr` is 4-byte aligned.
- `iresp`  out  `ibus_resp_t`  instruction response.
- `dreq`  in  `dbus_req_t`  data request; `strobe` is zero for reads.
- `dresp`  out  `dbus_resp_t`  data response.
- `creq`  out  `cbus_req_t`  cache-bus request.
- `cresp`  in  `cbus_resp_t`  cache-bus response.

## Operation
- FSM states: IDLE, REQ, DONE. Register `grant` records the owner: 0 = ibus, 1 = dbus.
- **IDLE**
  - If any `valid` is set, pick a winner (see Configuration) and latch that request into `req_q`.
  - An ibus request is latched through the IREQ_TO_DREQ mapping: `size`=MSIZE4, `strobe`=0, `data`=0.
  - Go to REQ.
- **REQ**
  - Drive `creq` from `req_q`: `valid`=1, `is_write`=|strobe, `size`, `addr`, `strobe` and `data` from the request.
  - Fixed fields: `len`=MLEN1, `burst`=AXI_BURST_FIXED.
  - `creq` stays stable until `cresp.ready && cresp.last`. On that cycle latch `cresp.data` into `rdata_q` and go to DONE.
  - `ready` without `last` is a protocol error; it is ignored and the bridge stays in REQ.
- **DONE**
  - For exactly one cycle, assert `addr_ok`=`data_ok`=1 on the granted bus only.
  - `dresp.data` = `rdata_q`.
  - `iresp.data` = `req_q.addr[2]` ? `rdata_q[63:32]` : `rdata_q[31:0]`.
  - Then go to IDLE.
- Masters hold `valid` and the request fields stable until `data_ok`.
- If the granted master drops `valid` mid-transaction, the cbus transaction still completes and `data_ok` still pulses.
- The non-granted master waits with no response; its request is re-arbitrated in the next IDLE.
- Writes return `data_ok` with `data` = the cbus response data, which the CPU ignores.
- The `creq` and `*resp` structs are zero whenever not driven as above. `creq.valid` is 1 only in REQ.

## Timing
- Reset (asynchronous, `reset_n`=0):
  - FSM goes to IDLE; `grant`, `req_q` and `rdata_q` are cleared.
  - All outputs are 0: `creq` = '0, `iresp` = '0, `dresp` = '0.
  - Reset mid-transaction abandons the cbus transaction silently; memory is reset by the same signal.
- Latency, cycles counted from the edge that samples `valid` in IDLE (cycle 0):
  - `creq.valid` is high from cycle 1.
  - With `cresp.ready && last` first seen in cycle k (k≥1), `data_ok` is in cycle k+1 and IDLE in cycle k+2.
  - Minimum request-to-`data_ok` is 2 cycles.
- Back-to-back: a new request is sampled no earlier than the IDLE cycle after DONE, so throughput is one transaction per ≥3 cycles.
- `creq` outputs are registered-state decodes. No combinational path exists from `cresp` to `creq`, or from `ireq`/`dreq` to `creq`.
- `*resp` outputs depend only on registered state.

## Configuration
- `MEM_BRIDGE_RR_ARB_EN`
  - **Defined:** round-robin arbitration. When both buses are valid in IDLE, the bus not granted last time wins. A single valid bus always wins.
  - **Undefined:** fixed priority, dbus over ibus whenever both are valid.
- The `grant` register exists in both builds. In the undefined build it only steers responses.

## Test plan
- **Single ibus read**
  - Stimulus: `ireq.addr`=0x8000_0004; memory returns 0x1122_3344_5566_7788 with ready & last 2 cycles after `creq.valid`.
  - Required: `creq` has `size`=MSIZE4, `is_write`=0, `len`=MLEN1; `iresp.data`=0x1122_3344 with `data_ok` for exactly 1 cycle; `dresp` stays 0.
- **dbus byte write**
  - Stimulus: `addr`=0x8000_1003, `strobe`=0x08, `data`=0x0000_0000_AB00_0000.
  - Required: `creq.is_write`=1 with matching `strobe`/`data`/`size`; `dresp.data_ok` pulses once.
- **Simultaneous requests**
  - Stimulus: ibus and dbus valid in the same cycle, held through two transactions.
  - Required, undefined build: dbus is served first.
  - Required, `MEM_BRIDGE_RR_ARB_EN` build: the grant alternates with the last grant. From reset (last grant ibus=0), dbus is served first, then ibus.
- **Stall**
  - Stimulus: hold `cresp.ready`=0 for 10 cycles, including one cycle of `ready`=1 with `last`=0.
  - Required: `creq` is stable throughout; completion occurs only on ready & last.
- **Reset mid-REQ**
  - Stimulus: pull `reset_n` low in a REQ cycle.
  - Required: `creq.valid`, `iresp` and `dresp` go to 0 immediately, without waiting for a clock edge; after release the next request starts cleanly from IDLE.
- **Dropped valid**
  - Stimulus: dbus deasserts `valid` during REQ.
  - Required: the transaction completes and `dresp.data_ok` still pulses 1 cycle.
